// File: rtl/mvm_tiled.sv
// mvm_tiled: matrix-vector multiply with bias, optional ReLU and saturation.
// Rows are processed LANES at a time; each pass spends SHARED_DIM cycles in
// MAC and one cycle in WRITE. Results appear on result_vector all at once.
//
// Handshake: start is a one-cycle request that is accepted only while the FSM
// is in IDLE (busy=0). On acceptance all operands and mode bits are captured,
// so inputs may change freely afterwards. done pulses for exactly one cycle,
// in the same cycle that result_vector first shows the new values and busy
// drops. A start in that same cycle is accepted.
module mvm_tiled #(
  parameter int MATRIX_ROWS = 3,
  parameter int SHARED_DIM  = 3,
  parameter int WIDTH       = 8,
  parameter int LANES       = 1,
  parameter int ACC_WIDTH   = 2*WIDTH+8
) (
  input  logic                                    clk,
  input  logic                                    reset,
  input  logic                                    start,
  input  logic                                    signed_mode,
  input  logic                                    sat_mode,
  input  logic                                    relu_en,
  input  logic [MATRIX_ROWS*SHARED_DIM*WIDTH-1:0] matrix,
  input  logic [SHARED_DIM*WIDTH-1:0]             vector,
  input  logic [MATRIX_ROWS*WIDTH-1:0]            bias,
  output logic                                    busy,
  output logic                                    done,
  output logic [MATRIX_ROWS*WIDTH-1:0]            result_vector
);

  localparam int PASSES = (MATRIX_ROWS + LANES - 1) / LANES;
  localparam int KW = (SHARED_DIM > 1) ? $clog2(SHARED_DIM) : 1;
  localparam int PW = (PASSES > 1) ? $clog2(PASSES) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(SHARED_DIM - 1);
  localparam logic [PW-1:0] P_LAST = PW'(PASSES - 1);
  localparam logic [ACC_WIDTH-1:0] SMAX = {{(ACC_WIDTH-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [ACC_WIDTH-1:0] SMIN = {{(ACC_WIDTH-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, MAC, WRITE} state_t;

  // FSM state kept as a named signal so checkers can bind to it directly.
  state_t state;

  logic [MATRIX_ROWS*SHARED_DIM*WIDTH-1:0] mat_q;
  logic [SHARED_DIM*WIDTH-1:0]             vec_q;
  logic [MATRIX_ROWS*WIDTH-1:0]            bias_q;
  logic                                    sgn_q, sat_q, relu_q;
  logic [KW-1:0]                           k;
  logic [PW-1:0]                           p;
  logic [ACC_WIDTH-1:0]                    acc [LANES];
  logic [ACC_WIDTH-1:0]                    prod [LANES];
  logic [MATRIX_ROWS*WIDTH-1:0]            row_buf;
  logic [MATRIX_ROWS*WIDTH-1:0]            next_buf;

  // Sign- or zero-extend one element to accumulator width.
  function automatic logic [ACC_WIDTH-1:0] ext(input logic [WIDTH-1:0] x, input logic sgn);
    return sgn ? {{(ACC_WIDTH-WIDTH){x[WIDTH-1]}}, x} : {{(ACC_WIDTH-WIDTH){1'b0}}, x};
  endfunction

  // Reduce an accumulator-width value to WIDTH by wrap or saturation.
  function automatic logic [WIDTH-1:0] reduce(input logic [ACC_WIDTH-1:0] s,
                                              input logic sgn, input logic sat);
    if (!sat) return s[WIDTH-1:0];
    if (sgn) begin
      if ($signed(s) > $signed(SMAX)) return SMAX[WIDTH-1:0];
      if ($signed(s) < $signed(SMIN)) return SMIN[WIDTH-1:0];
      return s[WIDTH-1:0];
    end
    if (|s[ACC_WIDTH-1:WIDTH]) return {WIDTH{1'b1}};
    return s[WIDTH-1:0];
  endfunction

  // Per-lane product for the current column and the finished row values for this pass.
  always_comb begin
    int r;
    int rs;
    logic [ACC_WIDTH-1:0] sum;
    r = 0;
    rs = 0;
    sum = '0;
    next_buf = row_buf;
    for (int l = 0; l < LANES; l++) begin
      r = int'(p) * LANES + l;
      rs = (r < MATRIX_ROWS) ? r : 0;
      prod[l] = ext(mat_q[(MATRIX_ROWS*SHARED_DIM-1-(rs*SHARED_DIM+int'(k)))*WIDTH +: WIDTH], sgn_q)
              * ext(vec_q[(SHARED_DIM-1-int'(k))*WIDTH +: WIDTH], sgn_q);
      if (r >= MATRIX_ROWS) prod[l] = '0;
      sum = acc[l] + ext(bias_q[(MATRIX_ROWS-1-rs)*WIDTH +: WIDTH], sgn_q);
      if (sgn_q && relu_q && sum[ACC_WIDTH-1]) sum = '0;
      if (r < MATRIX_ROWS)
        next_buf[(MATRIX_ROWS-1-rs)*WIDTH +: WIDTH] = reduce(sum, sgn_q, sat_q);
    end
  end

  // Control FSM with registered outputs, operand capture and accumulation.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      busy          <= 1'b0;
      done          <= 1'b0;
      result_vector <= '0;
      row_buf       <= '0;
      mat_q         <= '0;
      vec_q         <= '0;
      bias_q        <= '0;
      sgn_q         <= 1'b0;
      sat_q         <= 1'b0;
      relu_q        <= 1'b0;
      k             <= '0;
      p             <= '0;
      for (int l = 0; l < LANES; l++) acc[l] <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            mat_q  <= matrix;
            vec_q  <= vector;
            bias_q <= bias;
            sgn_q  <= signed_mode;
            sat_q  <= sat_mode;
            relu_q <= relu_en;
            k      <= '0;
            p      <= '0;
            for (int l = 0; l < LANES; l++) acc[l] <= '0;
            busy   <= 1'b1;
            state  <= MAC;
          end
        end
        MAC: begin
          for (int l = 0; l < LANES; l++) acc[l] <= acc[l] + prod[l];
          if (k == K_LAST) begin
            k     <= '0;
            state <= WRITE;
          end else begin
            k <= k + 1'b1;
          end
        end
        WRITE: begin
          row_buf <= next_buf;
          if (p == P_LAST) begin
            result_vector <= next_buf;
            done          <= 1'b1;
            busy          <= 1'b0;
            state         <= IDLE;
          end else begin
            p     <= p + 1'b1;
            k     <= '0;
            for (int l = 0; l < LANES; l++) acc[l] <= '0;
            state <= MAC;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
